result_ascii_fmt: RTL
=====================

# result_ascii_fmt

Sequential binary-to-decimal formatter between the arithmetic stages (ALU, GCD/LCM) and the text LCD driver. It accepts one result word per request and converts it to packed BCD with an iterative shift-add-3 (double-dabble) engine. It then renders a fixed-width ASCII field (sign column plus digits, leading zeros blanked) that the LCD driver copies directly into its character buffer. Start/busy/done handshake; outputs stay stable between conversions.

## Interface
- `WIDTH`, 12, binary input width. The number of shift iterations equals `WIDTH`.
- `DIGITS`, 4, number of decimal digits. The configuration must satisfy 10^`DIGITS` > 2^`WIDTH`.
- `lcdclk`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  conversion request. Sampled only in IDLE.
- `signed_mode`  in  1  1: interpret `bin_in` as two's complement. Sampled together with `start`.
- `bin_in`  in  `WIDTH`  value to convert. Sampled together with `start`.
- `busy`  out  1  a conversion is in progress.
- `done`  out  1  one-cycle pulse; new outputs are valid in this cycle.
- `bcd_out`  out  4*`DIGITS`  magnitude as packed BCD. Most significant digit is in the top nibble.
- `neg`  out  1  result was negative.
- `ascii_out`  out  8*(`DIGITS`+1)  character 0 (sign) is in the top byte, then digits from most to least significant.

## Operation
- **States**
  - IDLE → LOAD when `start`=1.
  - LOAD → SHIFT.
  - SHIFT → SHIFT while iteration count < `WIDTH`-1, else → FORMAT.
  - FORMAT → IDLE.
- **IDLE, `start`=1:** latch `bin_in` and `signed_mode`; set `busy`.
- **LOAD, magnitude:** if `signed_mode` and the MSB of `bin_in` is 1, magnitude = two's-complement negation and `neg_i`=1. Otherwise magnitude = `bin_in` and `neg_i`=0.
- **LOAD, range:** the magnitude fits in `WIDTH` bits unsigned, including -2^(`WIDTH`-1) → 2048.
- **LOAD, engine init:** clear the BCD accumulator and the iteration counter.
- **SHIFT, one iteration per cycle:**
  - Add 3 to every BCD digit that is ≥ 5.
  - Then shift {BCD, magnitude} left by 1.
  - Increment the counter.
  - Exactly `WIDTH` iterations are performed.
- **FORMAT:** register the results.
  - `bcd_out` ← accumulator; `neg` ← `neg_i`.
  - Sign character: 0x2D ('-') if `neg_i`, else 0x20.
  - Digit characters: 0x30 + digit.
  - Leading-zero blanking: every digit above the most significant nonzero digit becomes 0x20. The units digit is never blanked, so zero renders as "    0".
  - Also in FORMAT: `done` ← 1, `busy` ← 0.
- **Negative zero:** cannot occur. With `signed_mode`=1 and input 0, `neg`=0.
- **`start` while not IDLE:** ignored. Inputs are not re-sampled.
- **Output hold:** `bcd_out`, `neg` and `ascii_out` change only in FORMAT. They hold their values through later conversions until the next FORMAT.
- **Reset values (asynchronous, immediate, valid mid-conversion):**
  - state IDLE, `busy`=0, `done`=0, `neg`=0, `bcd_out`=0.
  - `ascii_out` = 0x2020202030.
  - Internal registers cleared. An aborted conversion produces no `done`.

## Timing
- `start` sampled high at edge N:
  - `busy`=1 after edge N.
  - LOAD at N+1.
  - SHIFT at edges N+2 … N+`WIDTH`+1.
  - FORMAT at N+`WIDTH`+2.
- Default configuration: `done`=1 and outputs updated after edge N+14. `done` falls after N+15. `busy` falls after N+14.
- Latency is `WIDTH`+2 cycles from the `start` edge to `done`.
- Back-to-back: a `start` held high through the `done` cycle is accepted at edge N+15, giving one conversion per 15 cycles.
- `done` and `busy` are never high in the same cycle.
- Upstream operands may change freely after the `start` edge.

## Structure
- **Shared package contents:**
  - the state typedef (IDLE, LOAD, SHIFT, FORMAT);
  - ASCII constants CH_SPACE = 0x20, CH_MINUS = 0x2D, CH_ZERO = 0x30;
  - the reset ASCII field constant.
- **Sub-module `bcd_digit_adj`:** one combinational instance per digit, 4-bit in/out: if in ≥ 5 then in+3, else in.
- **Top level:** owns the FSM, the counter (clog2(`WIDTH`) bits), the shift register and the formatting logic.

## Test plan
- **Unsigned maximum:** unsigned `bin_in`=0xFFF, `start` pulse → `done` 14 cycles later. `bcd_out`=0x4095, `neg`=0, `ascii_out`=0x2034303935 (" 4095").
- **Zero:** unsigned 0x000 → `bcd_out`=0x0000, `ascii_out`=0x2020202030. Repeat with `signed_mode`=1 → identical, `neg`=0.
- **Signed inputs and blanking:**
  - signed 0xFFF → `bcd_out`=0x0001, `neg`=1, `ascii_out`=0x2D20202031 ("-   1").
  - signed 0x800 → 0x2048, `ascii_out`=0x2D32303438.
  - unsigned 0x800 → 0x2032303438.
  - 0x064 unsigned → 0x2020313030 ("  100", internal zeros kept).
- **Start during busy:** `start` with 0x123, re-pulse `start` with 0x456 at cycle 5 → single `done`, `bcd_out`=0x0291. The second request is ignored. Then `start` held high → next `done` exactly 15 cycles after the first.
- **Reset mid-conversion:** `resetn` low at cycle 7 of a conversion of 0x7FF → outputs at reset values immediately, no `done`. A new `start` of 0x00A after release → `ascii_out`=0x2020203130 at the expected latency.

Source files
------------

// File: rtl/result_ascii_fmt_pkg.sv
// rtl/result_ascii_fmt_pkg.sv - shared state encoding and ASCII constants for the result formatter
package result_ascii_fmt_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOAD   = 2'd1;
    localparam state_t ST_SHIFT  = 2'd2;
    localparam state_t ST_FORMAT = 2'd3;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    // Reset field for the default 4-digit configuration: "    0"
    localparam logic [39:0] ASCII_RESET = {CH_SPACE, CH_SPACE, CH_SPACE, CH_SPACE, CH_ZERO};

endpackage

// File: rtl/result_ascii_fmt_if.sv
// rtl/result_ascii_fmt_if.sv - request/result bundle between arithmetic stages and the formatter
interface result_ascii_fmt_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
);
    logic                      start;
    logic                      signed_mode;
    logic [WIDTH-1:0]          bin_in;
    logic                      busy;
    logic                      done;
    logic [4*DIGITS-1:0]       bcd_out;
    logic                      neg;
    logic [8*(DIGITS+1)-1:0]   ascii_out;

    modport master (
        output start, signed_mode, bin_in,
        input  busy, done, bcd_out, neg, ascii_out
    );

    modport slave (
        input  start, signed_mode, bin_in,
        output busy, done, bcd_out, neg, ascii_out
    );
endinterface

// File: rtl/result_ascii_fmt_bcd_digit_adj.sv
// rtl/result_ascii_fmt_bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end
endmodule

// File: rtl/result_ascii_fmt.sv
// rtl/result_ascii_fmt.sv - iterative binary-to-BCD converter rendering a blanked, signed ASCII field
module result_ascii_fmt
    import result_ascii_fmt_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic               lcdclk,
    input  logic               resetn,
    result_ascii_fmt_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam int BW = 4 * DIGITS;
    localparam int AW = 8 * (DIGITS + 1);
    localparam logic [AW-1:0] ASCII_RST = {{DIGITS{CH_SPACE}}, CH_ZERO};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_i_q, neg_i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BW-1:0]    bcd_out_q, bcd_out_d;
    logic             neg_q, neg_d;
    logic [AW-1:0]    ascii_q, ascii_d;

    logic [BW-1:0]    acc_adj;
    logic [DIGITS-1:0] lead_nz;
    logic [AW-1:0]    ascii_fmt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_adj[4*g +: 4])
        );
    end

    // lead_nz[i] is set when digit i or any more significant digit is nonzero
    always_comb begin
        lead_nz   = '0;
        ascii_fmt = '0;
        lead_nz[DIGITS-1] = |acc_q[BW-1 -: 4];
        for (int i = DIGITS - 2; i >= 0; i--) begin
            lead_nz[i] = lead_nz[i+1] | (|acc_q[4*i +: 4]);
        end
        ascii_fmt[8*DIGITS +: 8] = neg_i_q ? CH_MINUS : CH_SPACE;
        for (int i = 0; i < DIGITS; i++) begin
            if (lead_nz[i] || (i == 0)) begin
                ascii_fmt[8*i +: 8] = CH_ZERO + {4'h0, acc_q[4*i +: 4]};
            end else begin
                ascii_fmt[8*i +: 8] = CH_SPACE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        sgn_d     = sgn_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_i_d   = neg_i_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_out_d = bcd_out_q;
        neg_d     = neg_q;
        ascii_d   = ascii_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_d   = bus.bin_in;
                    sgn_d   = bus.signed_mode;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Negating the most negative value wraps to 2^(WIDTH-1), which is still the right unsigned magnitude
                if (sgn_q && bin_q[WIDTH-1]) begin
                    mag_d   = -bin_q;
                    neg_i_d = 1'b1;
                end else begin
                    mag_d   = bin_q;
                    neg_i_d = 1'b0;
                end
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                {acc_d, mag_d} = {acc_adj, mag_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                bcd_out_d = acc_q;
                neg_d     = neg_i_q;
                ascii_d   = ascii_fmt;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge lcdclk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            sgn_q     <= 1'b0;
            mag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_i_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= '0;
            neg_q     <= 1'b0;
            ascii_q   <= ASCII_RST;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            sgn_q     <= sgn_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_i_q   <= neg_i_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_out_q <= bcd_out_d;
            neg_q     <= neg_d;
            ascii_q   <= ascii_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bcd_out   = bcd_out_q;
    assign bus.neg       = neg_q;
    assign bus.ascii_out = ascii_q;

endmodule
